wb_interconnect: RTL and testbench

Parametrised single-master, N-slave Wishbone B4 (classic) interconnect that replaces the hand-wired address decoder, read-data mux and OR-ed acknowledge in the SoC top level. It sits between the core's data/instruction Wishbone master port and the memory and peripheral slaves (SRAM, CLINT, LED driver, future devices). It adds registered address decode, per-transaction slave locking, bus-error responses for unmapped addresses, a watchdog timeout for hung slaves, and error-status capture.

---
 rtl/wb_interconnect.sv | 189 ++++++++++++++++++
 tb/tb_wb_interconnect.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_interconnect.sv
// Single-master, N-slave Wishbone B4 classic interconnect.
// Registered address decode, per-transaction slave lock, bus error on
// unmapped addresses, watchdog timeout for hung slaves and capture of the
// last error cause and address.
module wb_interconnect #(
    parameter int NUM_SLAVES     = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter logic [NUM_SLAVES*2*ADDR_WIDTH-1:0] RULES = '0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             rst,

    input  logic                             wbm_cyc_i,
    input  logic                             wbm_stb_i,
    input  logic                             wbm_we_i,
    input  logic [DATA_WIDTH/8-1:0]          wbm_sel_i,
    input  logic [ADDR_WIDTH-1:0]            wbm_adr_i,
    input  logic [DATA_WIDTH-1:0]            wbm_dat_i,
    output logic [DATA_WIDTH-1:0]            wbm_dat_o,
    output logic                             wbm_ack_o,
    output logic                             wbm_err_o,

    output logic [NUM_SLAVES-1:0]            wbs_cyc_o,
    output logic [NUM_SLAVES-1:0]            wbs_stb_o,
    output logic                             wbs_we_o,
    output logic [DATA_WIDTH/8-1:0]          wbs_sel_o,
    output logic [ADDR_WIDTH-1:0]            wbs_adr_o,
    output logic [DATA_WIDTH-1:0]            wbs_dat_o,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] wbs_dat_i,
    input  logic [NUM_SLAVES-1:0]            wbs_ack_i,
    input  logic [NUM_SLAVES-1:0]            wbs_err_i,

    output logic [1:0]                       err_code_o,
    output logic [ADDR_WIDTH-1:0]            err_adr_o
);

    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    // A zero timeout still needs a legal one-bit counter; it is never compared.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_UNMAPPED = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_SLAVE    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_ERROR  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    we_q;
    logic [SEL_W-1:0]        sel_q;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic [DATA_WIDTH-1:0]   dat_q;
    logic [1:0]              err_code_q;
    logic [ADDR_WIDTH-1:0]   err_adr_q;

    logic                    hit_d;
    logic [IDX_W-1:0]        hit_idx_d;

    logic                    sel_ack;
    logic                    sel_err;
    logic [DATA_WIDTH-1:0]   sel_dat;
    logic                    active;
    logic                    timeout;

    // Address decode; scanning downward lets the lowest matching index win.
    always_comb begin
        hit_d     = 1'b0;
        hit_idx_d = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((wbm_adr_i & RULES[2*i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                (RULES[(2*i+1)*ADDR_WIDTH +: ADDR_WIDTH] &
                 RULES[2*i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                hit_d     = 1'b1;
                hit_idx_d = IDX_W'(i);
            end
        end
    end

    // Response mux: only the locked slave's ack/err/data are ever looked at.
    always_comb begin
        sel_ack = 1'b0;
        sel_err = 1'b0;
        sel_dat = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_ack = wbs_ack_i[i];
                sel_err = wbs_err_i[i];
                sel_dat = wbs_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Dropping master cyc aborts combinationally, so nothing is driven or
    // reported in the abort cycle itself.
    assign active  = (state_q == S_ACTIVE) && wbm_cyc_i;
    // Any slave response in the last watchdog cycle takes priority.
    assign timeout = TIMEOUT_EN && (cnt_q == CNT_LAST) && !sel_ack && !sel_err;

    // Per-slave cycle/strobe: only the locked slave, only while active.
    always_comb begin
        wbs_cyc_o = '0;
        wbs_stb_o = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (active && (idx_q == IDX_W'(i))) begin
                wbs_cyc_o[i] = 1'b1;
                wbs_stb_o[i] = 1'b1;
            end
        end
    end

    assign wbm_ack_o = active && sel_ack;
    assign wbm_err_o = (active && !sel_ack && (sel_err || timeout)) ||
                       (state_q == S_ERROR);
    assign wbm_dat_o = active ? sel_dat : '0;

    assign wbs_we_o   = we_q;
    assign wbs_sel_o  = sel_q;
    assign wbs_adr_o  = adr_q;
    assign wbs_dat_o  = dat_q;
    assign err_code_o = err_code_q;
    assign err_adr_o  = err_adr_q;

    // Transaction FSM: accept/lock, watchdog, completion and error capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            err_code_q <= ERR_NONE;
            err_adr_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (wbm_cyc_i && wbm_stb_i) begin
                        idx_q   <= hit_idx_d;
                        we_q    <= wbm_we_i;
                        sel_q   <= wbm_sel_i;
                        adr_q   <= wbm_adr_i;
                        dat_q   <= wbm_dat_i;
                        state_q <= hit_d ? S_ACTIVE : S_ERROR;
                    end
                end
                S_ACTIVE: begin
                    if (!wbm_cyc_i) begin
                        state_q <= S_IDLE;
                    end else if (sel_ack) begin
                        state_q <= S_IDLE;
                    end else if (sel_err) begin
                        state_q    <= S_IDLE;
                        err_code_q <= ERR_SLAVE;
                        err_adr_q  <= adr_q;
                    end else if (timeout) begin
                        state_q    <= S_IDLE;
                        err_code_q <= ERR_TIMEOUT;
                        err_adr_q  <= adr_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_ERROR: begin
                    state_q    <= S_IDLE;
                    err_code_q <= ERR_UNMAPPED;
                    err_adr_q  <= adr_q;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_interconnect.sv
// Directed bench for wb_interconnect with a response scoreboard.
module tb_wb_interconnect;

    localparam int NS = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    // slave2: SRAM 0x8000_0000/0xFFFF_8000, slave1: CLINT 0x0200_0000/0xFF00_0000,
    // slave0: 0x0201_0000/0xFFFF_0000 (overlaps slave1).
    localparam logic [NS*2*AW-1:0] RULES = {
        32'h8000_0000, 32'hFFFF_8000,
        32'h0200_0000, 32'hFF00_0000,
        32'h0201_0000, 32'hFFFF_0000
    };

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          m_cyc = 1'b0, m_stb = 1'b0, m_we = 1'b0;
    logic [3:0]    m_sel = '0;
    logic [31:0]   m_adr = '0, m_dat = '0;
    logic [31:0]   wbm_dat_o;
    logic          wbm_ack_o, wbm_err_o;
    logic [NS-1:0] wbs_cyc_o, wbs_stb_o;
    logic          wbs_we_o;
    logic [3:0]    wbs_sel_o;
    logic [31:0]   wbs_adr_o, wbs_dat_o;
    logic [NS*DW-1:0] wbs_dat_i;
    logic [NS-1:0] wbs_ack_i, wbs_err_i;
    logic [1:0]    err_code_o;
    logic [31:0]   err_adr_o;

    wb_interconnect #(
        .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .RULES(RULES), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_we_i(m_we),
        .wbm_sel_i(m_sel), .wbm_adr_i(m_adr), .wbm_dat_i(m_dat),
        .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
        .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
        .wbs_sel_o(wbs_sel_o), .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o),
        .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
        .err_code_o(err_code_o), .err_adr_o(err_adr_o)
    );

    always #5 clk = ~clk;

    // Slave models: mode bit0 = ack, bit1 = err, 0 = never respond.
    // Response comes in the strobe cycle whose index equals waitn.
    logic [1:0]  mode  [NS];
    int          waitn [NS];
    logic [31:0] rdata [NS];
    int          wcnt  [NS];
    logic [NS-1:0] stray = '0;

    always_comb begin
        wbs_ack_i = '0;
        wbs_err_i = '0;
        wbs_dat_i = '0;
        for (int i = 0; i < NS; i++) begin
            wbs_ack_i[i] = (wbs_stb_o[i] && mode[i][0] && (wcnt[i] == waitn[i])) || stray[i];
            wbs_err_i[i] = wbs_stb_o[i] && mode[i][1] && (wcnt[i] == waitn[i]);
            wbs_dat_i[i*DW +: DW] = rdata[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++)
            wcnt[i] <= (rst || !wbs_stb_o[i]) ? 0 : wcnt[i] + 1;
    end

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        ack;
        logic        err;
        logic [31:0] dat;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic ack, input logic err, input logic [31:0] dat);
        exp_t e;
        e.ack = ack;
        e.err = err;
        e.dat = dat;
        sbq.push_back(e);
    endtask

    // Monitor: every master response must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && (wbm_ack_o || wbm_err_o)) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_resp: got ack=%b err=%b expected none", wbm_ack_o, wbm_err_o);
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_ack", 64'(wbm_ack_o), 64'(mon_e.ack));
                chk("sb_err", 64'(wbm_err_o), 64'(mon_e.err));
                if (mon_e.ack) chk("sb_dat", 64'(wbm_dat_o), 64'(mon_e.dat));
            end
        end
    end

    // One master transaction; lat is the response cycle (0 = sampling cycle).
    task automatic xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                        input logic [31:0] dat, output int lat,
                        output logic [NS-1:0] stb_at, output logic [NS-1:0] stb_acc);
        @(posedge clk); #1;
        m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_sel = sel; m_adr = adr; m_dat = dat;
        lat = -1;
        stb_at = '0;
        stb_acc = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            stb_acc |= wbs_stb_o;
            if (wbm_ack_o || wbm_err_o) begin
                lat = k;
                stb_at = wbs_stb_o;
                break;
            end
        end
        @(posedge clk); #1;
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
    endtask

    int            lat;
    logic [NS-1:0] sat, sacc;

    initial begin
        for (int i = 0; i < NS; i++) begin
            mode[i] = 2'b01; waitn[i] = 0; rdata[i] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ack", 64'(wbm_ack_o), 64'd0);
        chk("rst_err", 64'(wbm_err_o), 64'd0);
        chk("rst_dat", 64'(wbm_dat_o), 64'd0);
        chk("rst_cyc", 64'(wbs_cyc_o), 64'd0);
        chk("rst_stb", 64'(wbs_stb_o), 64'd0);
        chk("rst_code", 64'(err_code_o), 64'd0);
        chk("rst_eadr", 64'(err_adr_o), 64'd0);
        chk("rst_badr", 64'({wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o}), 64'd0);

        // Single zero-wait read from SRAM.
        rdata[2] = 32'hDEAD_BEEF;
        push(1'b1, 1'b0, 32'hDEAD_BEEF);
        xfer(32'h8000_0010, 1'b0, 4'hF, 32'h0, lat, sat, sacc);
        chk("rd_lat", 64'(lat), 64'd1);
        chk("rd_stb", 64'(sat), 64'(3'b100));
        @(negedge clk);
        chk("rd_stb_after", 64'(wbs_stb_o), 64'd0);
        chk("rd_code", 64'(err_code_o), 64'd0);

        // Write: broadcast fields registered at accept and held afterwards.
        rdata[2] = 32'h0BAD_F00D;
        push(1'b1, 1'b0, 32'h0BAD_F00D);
        xfer(32'h8000_0044, 1'b1, 4'b0011, 32'h1234_5678, lat, sat, sacc);
        chk("wr_lat", 64'(lat), 64'd1);
        @(negedge clk);
        chk("wr_bcast", 64'({wbs_we_o, wbs_sel_o, wbs_dat_o}), 64'({1'b1, 4'b0011, 32'h1234_5678}));
        chk("wr_adr", 64'(wbs_adr_o), 64'h8000_0044);

        // Unmapped address.
        push(1'b0, 1'b1, 32'h0);
        xfer(32'h1000_0000, 1'b0, 4'hF, 32'h0, lat, sat, sacc);
        chk("unm_lat", 64'(lat), 64'd1);
        chk("unm_stb", 64'(sacc), 64'd0);
        @(negedge clk);
        chk("unm_err_once", 64'(wbm_err_o), 64'd0);
        chk("unm_code", 64'(err_code_o), 64'd1);
        chk("unm_eadr", 64'(err_adr_o), 64'h1000_0000);

        // Timeout on a CLINT that never answers.
        mode[1] = 2'b00;
        push(1'b0, 1'b1, 32'h0);
        xfer(32'h0200_4000, 1'b0, 4'hF, 32'h0, lat, sat, sacc);
        chk("tmo_lat", 64'(lat), 64'd4);
        chk("tmo_stb", 64'(sat), 64'(3'b010));
        stray[1] = 1'b1;
        @(negedge clk);
        chk("tmo_stb_after", 64'(wbs_stb_o), 64'd0);
        chk("tmo_code", 64'(err_code_o), 64'd2);
        chk("tmo_eadr", 64'(err_adr_o), 64'h0200_4000);
        repeat (2) @(negedge clk);
        chk("tmo_late_ack", 64'(wbm_ack_o), 64'd0);
        stray[1] = 1'b0;

        // Overlap: slave 0 must win; stray ack on slave 2 must be ignored.
        mode[0] = 2'b01; waitn[0] = 1; rdata[0] = 32'h1111_2222;
        mode[1] = 2'b01; waitn[1] = 0; rdata[1] = 32'h3333_4444;
        stray[2] = 1'b1;
        push(1'b1, 1'b0, 32'h1111_2222);
        xfer(32'h0201_0000, 1'b0, 4'hF, 32'h0, lat, sat, sacc);
        stray[2] = 1'b0;
        chk("ovl_lat", 64'(lat), 64'd2);
        chk("ovl_stb", 64'(sacc), 64'(3'b001));

        // Slave error.
        mode[0] = 2'b10; waitn[0] = 0;
        push(1'b0, 1'b1, 32'h0);
        xfer(32'h0201_0004, 1'b0, 4'hF, 32'h0, lat, sat, sacc);
        chk("serr_lat", 64'(lat), 64'd1);
        @(negedge clk);
        chk("serr_code", 64'(err_code_o), 64'd3);
        chk("serr_eadr", 64'(err_adr_o), 64'h0201_0004);

        // Ack and err together: ack wins, no capture.
        mode[0] = 2'b11; rdata[0] = 32'h5555_AAAA;
        push(1'b1, 1'b0, 32'h5555_AAAA);
        xfer(32'h0201_0008, 1'b0, 4'hF, 32'h0, lat, sat, sacc);
        @(negedge clk);
        chk("both_eadr", 64'(err_adr_o), 64'h0201_0004);

        // Abort of a 3-wait-state access in its second strobe cycle.
        waitn[2] = 3; rdata[2] = 32'h7777_0000;
        @(posedge clk); #1;
        m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h8000_0020;
        @(negedge clk);
        @(negedge clk);
        chk("abt_stb_c1", 64'(wbs_stb_o), 64'(3'b100));
        @(posedge clk); #1;
        m_cyc = 1'b0; m_stb = 1'b0;
        @(negedge clk);
        chk("abt_cycstb", 64'({wbs_cyc_o, wbs_stb_o}), 64'd0);
        chk("abt_resp", 64'({wbm_ack_o, wbm_err_o}), 64'd0);
        repeat (5) @(negedge clk);
        chk("abt_code", 64'(err_code_o), 64'd3);
        waitn[2] = 0; rdata[2] = 32'hCAFE_F00D;
        push(1'b1, 1'b0, 32'hCAFE_F00D);
        xfer(32'h8000_0024, 1'b0, 4'hF, 32'h0, lat, sat, sacc);
        chk("abt_idle_lat", 64'(lat), 64'd1);

        // Reset in the middle of an access.
        waitn[2] = 3;
        @(posedge clk); #1;
        m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h8000_0030;
        @(negedge clk);
        @(negedge clk);
        chk("mrst_stb_c1", 64'(wbs_stb_o), 64'(3'b100));
        rst = 1'b1;
        #1;
        chk("mrst_slv", 64'({wbs_cyc_o, wbs_stb_o}), 64'd0);
        chk("mrst_mst", 64'({wbm_ack_o, wbm_err_o, wbm_dat_o}), 64'd0);
        chk("mrst_err", 64'({err_code_o, err_adr_o}), 64'd0);
        chk("mrst_badr", 64'(wbs_adr_o), 64'd0);
        m_cyc = 1'b0; m_stb = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(negedge clk);

        chk("sb_drain", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "bench watchdog expired");
    end

endmodule
